// File: rtl/store_buffer.sv
// store_buffer: in-order store FIFO that owns the single data_memory port.
// Loads take the port in their accept cycle and forward from the youngest
// buffered store to the same address. Stores drain one per cycle when the
// port is free.
//
// state     | meaning
// ----------+--------------------------------------------
// S_EMPTY   | count == 0, nothing to drain
// S_PARTIAL | 0 < count < DEPTH, accepting and draining
// S_FULL    | count == DEPTH, req_ready low until a pop
module store_buffer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              drain_hold,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              empty,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_memwrite,
    output logic              mem_memread,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_PARTIAL,
        S_FULL
    } state_t;

    state_t            state, state_next;
    logic [PTR_W-1:0]  head, tail;
    logic [CNT_W-1:0]  count, count_next;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    logic              load_acc, store_acc, drain;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic [PTR_W-1:0]  fwd_idx;

    assign req_ready = (state != S_FULL);
    assign empty     = (state == S_EMPTY);

    // Handshake decode; a load accept owns the port, so it blocks the drain.
    always_comb begin
        load_acc  = req_valid & req_ready & ~req_write;
        store_acc = req_valid & req_ready & req_write;
        drain     = ~load_acc & (state != S_EMPTY) & ~drain_hold;
    end

    // Memory port mux; forced idle while reset is asserted.
    always_comb begin
        mem_addr       = '0;
        mem_write_data = '0;
        mem_memwrite   = 1'b0;
        mem_memread    = 1'b0;
        if (!reset) begin
            if (load_acc) begin
                mem_memread = 1'b1;
                mem_addr    = req_addr;
            end else if (drain) begin
                mem_memwrite   = 1'b1;
                mem_addr       = addr_q[head];
                mem_write_data = data_q[head];
            end
        end
    end

    // Forwarding search from oldest to youngest so the youngest match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && (addr_q[fwd_idx] == req_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[fwd_idx];
            end
        end
    end

    // Occupancy and next-state: +1 on push, -1 on pop, unchanged on both.
    always_comb begin
        count_next = count;
        case ({store_acc, drain})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
        if (count_next == '0)
            state_next = S_EMPTY;
        else if (count_next == DEPTH_C)
            state_next = S_FULL;
        else
            state_next = S_PARTIAL;
    end

    // State, pointers and load response registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_EMPTY;
            count     <= '0;
            head      <= '0;
            tail      <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            state     <= state_next;
            count     <= count_next;
            rsp_valid <= load_acc;
            if (drain)
                head <= head + PTR_W'(1);
            if (store_acc)
                tail <= tail + PTR_W'(1);
            if (load_acc)
                rsp_data <= fwd_hit ? fwd_data : mem_read_data;
        end
    end

    // FIFO storage; contents are meaningful only below count, so no reset.
    always_ff @(posedge clk) begin
        if (store_acc) begin
            addr_q[tail] <= req_addr;
            data_q[tail] <= req_wdata;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios plus random traffic against a
// queue-based model of pending stores and a reference memory image.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [15:0] req_addr, req_wdata;
    logic        drain_hold;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        empty;
    logic [15:0] mem_addr, mem_write_data;
    logic        mem_memwrite, mem_memread;
    logic [15:0] mem_read_data;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] d;
    } ent_t;

    ent_t        sb_q[$];
    logic [15:0] mem     [0:65535];
    logic [15:0] ref_mem [0:65535];
    logic [15:0] rsp_exp_data;
    logic        rsp_exp_valid;
    int          n_checks = 0;
    int          n_fail   = 0;

    store_buffer #(.DATA_W(16), .ADDR_W(16), .DEPTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .drain_hold     (drain_hold),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .empty          (empty),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_memwrite   (mem_memwrite),
        .mem_memread    (mem_memread),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;

    // data_memory stand-in: synchronous write, combinational read.
    always @(posedge clk) if (mem_memwrite) mem[mem_addr] <= mem_write_data;
    assign mem_read_data = mem_memread ? mem[mem_addr] : 16'h0000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One request cycle: drive, check port decisions, update model, check response.
    task automatic step(input logic v, input logic w, input logic [15:0] a,
                        input logic [15:0] d, input logic h);
        logic        rdy_e, ld, st;
        logic [15:0] fd;
        @(negedge clk);
        req_valid = v; req_write = w; req_addr = a; req_wdata = d; drain_hold = h;
        #1;
        rdy_e = (sb_q.size() < 4);
        chk("req_ready", req_ready, rdy_e);
        ld = v && rdy_e && !w;
        st = v && rdy_e && w;
        fd = 16'h0000;
        if (ld) begin
            chk("ld_memread", mem_memread, 1);
            chk("ld_memwrite", mem_memwrite, 0);
            chk("ld_addr", mem_addr, a);
            fd = ref_mem[a];
            foreach (sb_q[i]) if (sb_q[i].a == a) fd = sb_q[i].d;
        end else if (sb_q.size() > 0 && !h) begin
            chk("dr_memwrite", mem_memwrite, 1);
            chk("dr_memread", mem_memread, 0);
            chk("dr_addr", mem_addr, sb_q[0].a);
            chk("dr_wdata", mem_write_data, sb_q[0].d);
            ref_mem[sb_q[0].a] = sb_q[0].d;
            void'(sb_q.pop_front());
        end else begin
            chk("idle_memwrite", mem_memwrite, 0);
            chk("idle_memread", mem_memread, 0);
            chk("idle_addr", mem_addr, 0);
            chk("idle_wdata", mem_write_data, 0);
        end
        if (st) sb_q.push_back('{a: a, d: d});
        @(posedge clk);
        #1;
        rsp_exp_valid = ld;
        if (ld) rsp_exp_data = fd;
        chk("rsp_valid", rsp_valid, rsp_exp_valid);
        chk("rsp_data", rsp_data, rsp_exp_data);
        chk("empty", empty, sb_q.size() == 0);
    endtask

    // Reset asserted while a load is presented: nothing must leak out.
    task automatic reset_mid(input logic [15:0] a);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = a; drain_hold = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_empty", empty, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_memwrite", mem_memwrite, 0);
        chk("rst_memread", mem_memread, 0);
        @(posedge clk);
        #1;
        chk("rst_no_rsp", rsp_valid, 0);
        @(negedge clk);
        reset = 1'b0; req_valid = 1'b0;
        sb_q.delete();
        rsp_exp_valid = 1'b0;
        rsp_exp_data  = 16'h0000;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 16'h0000;
            ref_mem[i] = 16'h0000;
        end
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0;
        req_addr = '0; req_wdata = '0; drain_hold = 1'b0;
        rsp_exp_valid = 1'b0; rsp_exp_data = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_empty", empty, 1);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_data", rsp_data, 0);
        chk("reset_ready", req_ready, 1);
        chk("reset_memwrite", mem_memwrite, 0);
        @(negedge clk);
        reset = 1'b0;

        // single store drains the following cycle
        step(1, 1, 16'h0010, 16'h0C02, 0);
        step(0, 0, 16'h0000, 16'h0000, 0);
        step(0, 0, 16'h0000, 16'h0000, 0);

        // plain load from memory
        mem[16'h0004] = 16'h0502; ref_mem[16'h0004] = 16'h0502;
        step(1, 0, 16'h0004, 16'h0000, 0);
        step(0, 0, 16'h0000, 16'h0000, 0);

        // fill under hold, rejected fifth store, then ordered drain
        for (int i = 1; i <= 4; i++) step(1, 1, 16'(i), 16'hA000 + 16'(i), 1);
        step(1, 1, 16'h0005, 16'hA005, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 16'h0000, 16'h0000, 0);

        // youngest-match forwarding
        step(1, 1, 16'h0020, 16'h1111, 1);
        step(1, 1, 16'h0020, 16'h2222, 1);
        step(1, 0, 16'h0020, 16'h0000, 1);
        step(0, 0, 16'h0000, 16'h0000, 0);
        step(0, 0, 16'h0000, 16'h0000, 0);
        step(1, 0, 16'h0020, 16'h0000, 0);

        // loads interleaved with pending stores
        step(1, 1, 16'h0030, 16'h3333, 1);
        step(1, 1, 16'h0031, 16'h4444, 1);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 16'h0031, 16'h0000, 0);
            step(0, 0, 16'h0000, 16'h0000, 0);
        end

        // reset with stores pending and a load presented
        for (int i = 0; i < 3; i++) step(1, 1, 16'h0040 + 16'(i), 16'hBEE0 + 16'(i), 1);
        reset_mid(16'h0040);
        for (int i = 0; i < 4; i++) step(0, 0, 16'h0000, 16'h0000, 0);
        step(1, 0, 16'h0040, 16'h0000, 0);

        // random traffic over a small address window to exercise forwarding
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 299) == 0)
                reset_mid(16'($urandom_range(0, 7)));
            else
                step($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
                     16'($urandom_range(0, 7)), 16'($urandom),
                     $urandom_range(0, 9) < 3);
        end
        for (int i = 0; i < 6; i++) step(0, 0, 16'h0000, 16'h0000, 0);
        for (int i = 0; i < 80; i++) chk("final_mem", mem[i], ref_mem[i]);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
